// File: rtl/gpio_debounce_if.sv
// rtl/gpio_debounce_if.sv - pin, configuration and event bundle of the GPIO input conditioner
interface gpio_debounce_if #(
  parameter int GW = 32,
  parameter int PW = 16,
  parameter int CW = 8
);
  logic [GW-1:0] gpio_i;
  logic [PW-1:0] cfg_div;
  logic [CW-1:0] cfg_thr;
  logic [GW-1:0] cfg_ena;
  logic [GW-1:0] gpio_o;
  logic [GW-1:0] gpio_rise;
  logic [GW-1:0] gpio_fall;

  modport master (
    output gpio_i, cfg_div, cfg_thr, cfg_ena,
    input  gpio_o, gpio_rise, gpio_fall
  );

  modport slave (
    input  gpio_i, cfg_div, cfg_thr, cfg_ena,
    output gpio_o, gpio_rise, gpio_fall
  );
endinterface

// File: rtl/gpio_debounce.sv
// rtl/gpio_debounce.sv - per-bit GPIO synchronizer, prescaled debounce filter and edge pulse generator
module gpio_debounce #(
  parameter int GW      = 32,
  parameter int CFG_CDC = 2,
  parameter int PW      = 16,
  parameter int CW      = 8
) (
  input logic            clk,
  input logic            rst_n,
  gpio_debounce_if.slave bus
);
  logic [GW-1:0] gpio_s;

  generate
    if (CFG_CDC == 0) begin : g_nosync
      assign gpio_s = bus.gpio_i;
    end else begin : g_sync
      logic [GW-1:0] chain [CFG_CDC];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int k = 0; k < CFG_CDC; k++) chain[k] <= '0;
        end else begin
          chain[0] <= bus.gpio_i;
          for (int k = 1; k < CFG_CDC; k++) chain[k] <= chain[k-1];
        end
      end

      assign gpio_s = chain[CFG_CDC-1];
    end
  endgenerate

  // >= rather than == so a cfg_div lowered below the running count ticks at once
  logic [PW-1:0] pcnt;
  logic          tick;

  assign tick = (pcnt >= bus.cfg_div);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt <= '0;
    end else if (tick) begin
      pcnt <= '0;
    end else begin
      pcnt <= pcnt + PW'(1);
    end
  end

  logic [CW-1:0] cnt [GW];
  logic [GW-1:0] stable;
  logic [GW-1:0] stable_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stable   <= '0;
      stable_q <= '0;
      for (int i = 0; i < GW; i++) cnt[i] <= '0;
    end else begin
      stable_q <= stable;
      for (int i = 0; i < GW; i++) begin
        if (!bus.cfg_ena[i]) begin
          stable[i] <= gpio_s[i];
          cnt[i]    <= '0;
        end else if (tick) begin
          // count stays <= cfg_thr, so a lowered threshold accepts on the next tick
          if (gpio_s[i] == stable[i]) begin
            cnt[i] <= '0;
          end else if (cnt[i] >= bus.cfg_thr) begin
            stable[i] <= gpio_s[i];
            cnt[i]    <= '0;
          end else begin
            cnt[i] <= cnt[i] + CW'(1);
          end
        end
      end
    end
  end

  assign bus.gpio_o    = stable;
  assign bus.gpio_rise = stable & ~stable_q;
  assign bus.gpio_fall = ~stable & stable_q;
endmodule
